// File: rtl/laplace_uart_rx_if.sv
// Received-byte bundle from the UART receiver to its consumer.
interface laplace_uart_rx_if #(
   parameter int W = 8
);
   logic [W-1:0] data_out;
   logic         data_valid;
   logic         frame_err;

   modport master (output data_out, data_valid, frame_err);
   modport slave  (input  data_out, data_valid, frame_err);
endinterface

// File: rtl/laplace_uart_rx.sv
// 8N1 UART receiver for the LUT transmitter's tx line, plus an expected-character countdown.
// state | meaning
// IDLE  | waiting for rx_s low (start edge)
// START | checking the start bit at mid-bit
// DATA  | sampling payload bits at mid-bit, LSB first
// STOP  | sampling the stop bit; emits data_valid or frame_err
module laplace_uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 rx,
   input  logic                 load,
   input  logic [7:0]           load_count,
   laplace_uart_rx_if.master    bus,
   output logic [7:0]           chars_remaining,
   output logic                 done,
   output logic [3:0]           which_state
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] BIT_M1  = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_START = 4'd1,
      S_DATA  = 4'd2,
      S_STOP  = 4'd3
   } state_t;

   state_t                 state, state_nxt;
   logic                   rx_m, rx_s;
   logic [TW-1:0]          timer;
   logic [BW-1:0]          bit_cnt;
   logic [DATA_BITS-1:0]   shreg;
   logic [DATA_BITS-1:0]   data_q;
   logic                   valid_q, err_q;
   logic                   tick;
   logic                   start_frame, shift_bit, accept, reject;

   assign tick = (timer == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!ena) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (!rx_s) state_nxt = S_START;
            S_START: if (tick) state_nxt = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (tick && (bit_cnt == LAST_BIT)) state_nxt = S_STOP;
            S_STOP:  if (tick) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      start_frame = ena && (state == S_IDLE) && !rx_s;
      shift_bit   = ena && (state == S_DATA) && tick;
      accept      = ena && (state == S_STOP) && tick && rx_s;
      reject      = ena && (state == S_STOP) && tick && !rx_s;
   end

   // Timer first expires at mid start bit, then reloads for one full bit per sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer   <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= accept;
         err_q   <= reject;
         if (start_frame) begin
            timer   <= HALF_M1;
            bit_cnt <= '0;
         end else if (ena && (state != S_IDLE)) begin
            timer <= tick ? BIT_M1 : timer - 1'b1;
         end
         if (shift_bit) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (accept) data_q <= shreg;
      end
   end

   // A load in the same cycle as a valid byte takes precedence; that byte goes uncounted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chars_remaining <= 8'd0;
         done            <= 1'b0;
      end else if (load) begin
         chars_remaining <= load_count;
         done            <= (load_count == 8'd0);
      end else if (valid_q && (chars_remaining != 8'd0)) begin
         chars_remaining <= chars_remaining - 8'd1;
         done            <= (chars_remaining == 8'd1);
      end
   end

   assign bus.data_out   = data_q;
   assign bus.data_valid = valid_q;
   assign bus.frame_err  = err_q;
   assign which_state    = state;
endmodule

// File: tb/tb_laplace_uart_rx.sv
// Directed bench for laplace_uart_rx: scoreboarded bytes, counter, glitch, enable and reset cases.
module tb_laplace_uart_rx;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       rx = 1'b1;
   logic       load = 1'b0;
   logic [7:0] load_count = 8'd0;
   logic [7:0] chars_remaining;
   logic       done;
   logic [3:0] which_state;

   laplace_uart_rx_if #(.W(8)) bus ();

   laplace_uart_rx dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ena             (ena),
      .rx              (rx),
      .load            (load),
      .load_count      (load_count),
      .bus             (bus),
      .chars_remaining (chars_remaining),
      .done            (done),
      .which_state     (which_state)
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   int         fall_cyc = 0;
   int         last_valid_cyc = 0;
   int         err_seen = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_byte;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.data_valid) begin
            last_valid_cyc = cyc;
            vectors++;
            assert (exp_q.size() != 0) else begin
               miscompares++;
               $error("FAIL unexpected_valid observed=%0h expected=no_byte", bus.data_out);
            end
            if (exp_q.size() != 0) begin
               exp_byte = exp_q.pop_front();
               check("rx_byte", {24'd0, bus.data_out}, {24'd0, exp_byte});
            end
         end
         if (bus.frame_err) err_seen++;
         if (bus.data_valid || bus.frame_err)
            check("valid_err_exclusive", {31'd0, bus.data_valid & bus.frame_err}, 32'd0);
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop, input int drop_bit);
      @(negedge clk);
      rx = 1'b0;
      fall_cyc = cyc;
      if (stop && drop_bit < 0) exp_q.push_back(b);
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         if (i == drop_bit) ena = 1'b0;
         rx = b[i];
         repeat (16) @(negedge clk);
      end
      rx = stop;
      repeat (16) @(negedge clk);
      rx = 1'b1;
      if (drop_bit >= 0) ena = 1'b1;
   endtask

   task automatic do_load(input logic [7:0] n);
      @(negedge clk);
      load = 1'b1;
      load_count = n;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_data_out"}, {24'd0, bus.data_out}, 32'd0);
      check({tag, "_valid"}, {31'd0, bus.data_valid}, 32'd0);
      check({tag, "_err"}, {31'd0, bus.frame_err}, 32'd0);
      check({tag, "_chars"}, {24'd0, chars_remaining}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_state"}, {28'd0, which_state}, 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      ena = 1'b1;
      repeat (5) @(negedge clk);

      // 1: single byte and latency; count stays 0 without a prior load
      send_byte(8'h41, 1'b1, -1);
      check("latency", last_valid_cyc - fall_cyc, 32'd155);
      check("t1_data_out", {24'd0, bus.data_out}, 32'h41);
      check("t1_chars", {24'd0, chars_remaining}, 32'd0);
      check("t1_done", {31'd0, done}, 32'd0);
      check("t1_err", err_seen, 32'd0);

      // 2: countdown over back-to-back bytes
      do_load(8'd3);
      check("t2_load_chars", {24'd0, chars_remaining}, 32'd3);
      check("t2_load_done", {31'd0, done}, 32'd0);
      send_byte(8'h48, 1'b1, -1);
      check("t2_chars_a", {24'd0, chars_remaining}, 32'd2);
      send_byte(8'h49, 1'b1, -1);
      check("t2_chars_b", {24'd0, chars_remaining}, 32'd1);
      check("t2_done_b", {31'd0, done}, 32'd0);
      send_byte(8'h0A, 1'b1, -1);
      check("t2_chars_c", {24'd0, chars_remaining}, 32'd0);
      check("t2_done_c", {31'd0, done}, 32'd1);
      send_byte(8'h21, 1'b1, -1);
      check("t2_chars_sat", {24'd0, chars_remaining}, 32'd0);
      check("t2_done_sat", {31'd0, done}, 32'd1);

      // 3: stop bit low
      send_byte(8'h55, 1'b0, -1);
      repeat (40) @(negedge clk);
      check("t3_err_count", err_seen, 32'd1);
      check("t3_data_held", {24'd0, bus.data_out}, 32'h21);
      check("t3_chars", {24'd0, chars_remaining}, 32'd0);
      check("t3_state", {28'd0, which_state}, 32'd0);

      // 4: 4-cycle glitch is rejected at mid start bit
      @(negedge clk);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      check("t4_in_start", {28'd0, which_state}, 32'd1);
      repeat (2) @(negedge clk);
      check("t4_back_idle", {28'd0, which_state}, 32'd0);
      repeat (20) @(negedge clk);

      // 5: enable dropped mid-frame, then a byte whose valid collides with a load
      do_load(8'd7);
      send_byte(8'hA5, 1'b1, 3);
      repeat (20) @(negedge clk);
      check("t5_after_drop_data", {24'd0, bus.data_out}, 32'h21);
      check("t5_after_drop_chars", {24'd0, chars_remaining}, 32'd7);
      fork
         send_byte(8'h3C, 1'b1, -1);
         begin
            @(negedge clk);
            repeat (155) @(negedge clk);
            load = 1'b1;
            load_count = 8'd5;
            @(negedge clk);
            load = 1'b0;
         end
      join
      check("t5_data_out", {24'd0, bus.data_out}, 32'h3C);
      check("t5_load_wins", {24'd0, chars_remaining}, 32'd5);
      check("t5_done", {31'd0, done}, 32'd0);

      // 6: reset in the middle of a frame
      @(negedge clk);
      rx = 1'b0;
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_vals("t6_rst");
      rx = 1'b1;
      repeat (5) @(negedge clk);
      check_reset_vals("t6_hold");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      send_byte(8'hFF, 1'b1, -1);
      check("t6_data_out", {24'd0, bus.data_out}, 32'hFF);
      repeat (10) @(negedge clk);

      check("pending_bytes", exp_q.size(), 32'd0);
      check("total_frame_err", err_seen, 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
